// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size codes,
// FSM states and default data-memory depth.
package lsu_pkg;

  localparam int unsigned MEM_WORDS_DEF = 41;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_LDRESP,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction for loads and read-modify-write merge
// for sub-word stores; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        sgn_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [4:0]  sh;

  always_comb begin
    sh   = {lane_i, 3'b000};
    b    = rdata_i[{lane_i, 3'b000} +: 8];
    h    = rdata_i[{lane_i[1], 4'b0000} +: 16];
    ld_o = rdata_i;
    mask = 32'hFFFF_FFFF;
    unique case (size_i)
      SZ_BYTE: begin
        ld_o = {{24{sgn_i & b[7]}}, b};
        mask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        ld_o = {{16{sgn_i & h[15]}}, h};
        mask = 32'h0000_FFFF;
      end
      default: begin
        ld_o = rdata_i;
        mask = 32'hFFFF_FFFF;
      end
    endcase
    st_o = (rdata_i & ~(mask << sh))
         | ((wdata_i & mask) << sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts load/store requests,
// checks them, and sequences the registered-read memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_signal,
  input  logic [31:0] mem_read_data
);

  state_e      state_q;
  size_e       size_q;
  logic [1:0]  lane_q;
  logic        sgn_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q;

  logic [29:0] idx;
  logic [1:0]  lane;
  logic        req_err;
  logic [31:0] ld_word;
  logic [31:0] st_word;

  assign idx  = req_addr[31:2];
  assign lane = req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (req_size == SZ_ILL):
        req_err = 1'b1;
      (req_size == SZ_HALF):
        req_err = lane[0];
      (req_size == SZ_WORD):
        req_err = (lane != 2'd0);
      default:
        req_err = 1'b0;
    endcase
    if ({2'b00, idx} >= MEM_WORDS)
      req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'd0;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            size_q  <= size_e'(req_size);
            lane_q  <= lane;
            sgn_q   <= req_signed;
            wr_q    <= req_write;
            wdata_q <= req_wdata;
            if (req_err) begin
              state_q <= S_ERR;
            end else begin
              addr_q <= {2'b00, idx};
              if (req_write
                  && req_size == SZ_WORD)
                state_q <= S_WR;
              else
                state_q <= S_RD;
            end
          end
        end
        S_RD:
          state_q <= wr_q ? S_WR : S_LDRESP;
        S_WR:
          state_q <= S_DONE;
        S_LDRESP, S_DONE, S_ERR:
          state_q <= S_IDLE;
        default:
          state_q <= S_IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .size_i  (size_q),
    .lane_i  (lane_q),
    .sgn_i   (sgn_q),
    .rdata_i (mem_read_data),
    .wdata_i (wdata_q),
    .ld_o    (ld_word),
    .st_o    (st_word)
  );

  // Memory holds read data while written, so merge is stable in WR.
  assign req_ready        = (state_q == S_IDLE);
  assign mem_address      = addr_q;
  assign mem_write_signal = (state_q == S_WR);
  assign mem_write_data   =
    (state_q == S_WR) ? st_word : 32'h0;
  assign rsp_valid = (state_q == S_LDRESP)
                  || (state_q == S_DONE)
                  || (state_q == S_ERR);
  assign rsp_error = (state_q == S_ERR);
  assign rsp_rdata =
    (state_q == S_LDRESP) ? ld_word : 32'h0;

endmodule
